// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared output register for N_REQ valid/ready requesters.
// Define ARB_BURST_LOCK_EN to hold a grant from a requester's first beat through its req_last beat.
module mux_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_last,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] ptr;
    logic [PW-1:0] own;
    logic [PW-1:0] sel;
    logic          cand;
    logic          load_en;
    logic          accept;

    // (v + step) mod N_REQ for v, step < N_REQ
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] v, input int unsigned step);
        int unsigned s;
        s = 32'(v) + step;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return PW'(s);
    endfunction

    // Candidate: locked owner, or first valid requester at or after ptr
    always_comb begin
        sel  = ptr;
        cand = 1'b0;
        if (state == LOCKED) begin
            sel  = own;
            cand = req_valid[own];
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!cand && req_valid[wrap_add(ptr, i)]) begin
                    sel  = wrap_add(ptr, i);
                    cand = 1'b1;
                end
            end
        end
    end

    assign load_en = !out_valid || out_ready;
    assign accept  = load_en && cand && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
`ifdef ARB_BURST_LOCK_EN
        if (accept) begin
            if (state == IDLE && !req_last[sel]) begin
                state_next = LOCKED;
            end else if (state == LOCKED && req_last[sel]) begin
                state_next = IDLE;
            end
        end
`else
        state_next = IDLE;
`endif
    end

`ifndef ARB_BURST_LOCK_EN
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    // Output register, pointer and burst owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            grant     <= '0;
            ptr       <= '0;
            own       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= req_data[sel*WIDTH +: WIDTH];
            grant     <= N_REQ'(1) << sel;
            ptr       <= wrap_add(sel, 1);
            if (state == IDLE && state_next == LOCKED) begin
                own <= sel;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            grant     <= '0;
        end
    end

    assign busy = (state == LOCKED);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: per-cycle reference model plus directed scenarios.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    mux_rr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: abstract state of the arbiter
    int         m_ptr    = 0;
    bit         m_locked = 0;
    int         m_own    = 0;
    bit         m_ov     = 0;
    logic [7:0] m_od     = 8'h00;
    int         m_gnt    = -1;

    function automatic int pick();
        if (rst) return -1;
        if (m_ov && !out_ready) return -1;
        if (m_locked) return req_valid[m_own] ? m_own : -1;
        for (int i = 0; i < N; i++) begin
            if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_ptr = 0; m_locked = 0; m_own = 0; m_ov = 0; m_od = 8'h00; m_gnt = -1;
        end else begin
            g = pick();
            if (g >= 0) begin
                m_ov  = 1;
                m_od  = req_data[g*W +: W];
                m_gnt = g;
                m_ptr = (g + 1) % N;
`ifdef ARB_BURST_LOCK_EN
                if (!m_locked && !req_last[g]) begin
                    m_locked = 1;
                    m_own    = g;
                end else if (m_locked && req_last[g]) begin
                    m_locked = 0;
                end
`endif
            end else if (out_ready) begin
                m_ov  = 0;
                m_gnt = -1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int g;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_grant;
        g       = pick();
        e_ready = (g >= 0) ? N'(1 << g) : '0;
        e_grant = (m_gnt >= 0) ? N'(1 << m_gnt) : '0;
        chk("model_req_ready", 32'(req_ready), 32'(e_ready));
        chk("model_out_valid", 32'(out_valid), 32'(m_ov));
        chk("model_out_data", 32'(out_data), 32'(m_od));
        chk("model_grant", 32'(grant), 32'(e_grant));
        chk("model_busy", 32'(busy), 32'(m_locked));
    end

    task automatic set_data(input int k, input logic [7:0] v);
        req_data[k*W +: W] = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         cnt [N];
    logic [N-1:0] acc;
    logic [7:0] exp_d [5];
    logic       exp_b [5];
    int         c0;

    initial begin
        rst = 1'b0; req_valid = '0; req_last = '1; req_data = '0; out_ready = 1'b1;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        #1 rst = 1'b1;
        req_valid = '1;
        for (int k = 0; k < N; k++) set_data(k, 8'(k * 16));

        // Reset values, ready gated by reset
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;

        // Round robin, all valid, data k*16+beat
        for (int b = 0; b < 9; b++) begin
            @(negedge clk);
            if (b == 0) chk("rr_first_ready", 32'(req_ready), 32'h1);
            if (b > 0) begin
                chk("rr_data", 32'(out_data), 32'(((b - 1) % 4) * 16 + (b - 1) / 4));
                chk("rr_grant", 32'(grant), 32'(1 << ((b - 1) % 4)));
                chk("rr_valid", 32'(out_valid), 32'd1);
            end
            if (b == 8) req_valid = '0;
            acc = req_valid & req_ready;
            step();
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    cnt[k]++;
                    set_data(k, 8'(k * 16 + cnt[k]));
                end
            end
        end

        // Backpressure on requester 2
        req_valid = 4'b0100; set_data(2, 8'hA5); out_ready = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_data", 32'(out_data), 32'hA5);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'h0);
            step();
        end
        set_data(2, 8'h5A); out_ready = 1'b1;
        @(negedge clk);
        chk("bp_reload_ready", 32'(req_ready), 32'h4);
        step();

        // Sparse: steer ptr to 1, then only requester 3
        req_valid = 4'b0001; set_data(0, 8'h77);
        @(negedge clk);
        chk("bp_new_data", 32'(out_data), 32'h5A);
        chk("sp_ready0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b1000; set_data(3, 8'h3C);
        @(negedge clk);
        chk("sp_ready3", 32'(req_ready), 32'h8);
        step();
        req_valid = 4'b1001; set_data(0, 8'h0F);
        @(negedge clk);
        chk("sp_data3", 32'(out_data), 32'h3C);
        chk("sp_grant3", 32'(grant), 32'h8);
        chk("sp_wrap_ready0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("sp_data0", 32'(out_data), 32'h0F);
        chk("sp_grant0", 32'(grant), 32'h1);

        // Asynchronous reset mid-cycle while out_valid is high
        #2;
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst = 1'b0;

        // Burst: requester 0 sends C0..C3, requester 1 always valid with D0
`ifdef ARB_BURST_LOCK_EN
        exp_d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        exp_d = '{8'hC0, 8'hD0, 8'hC1, 8'hD0, 8'hC2};
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        c0 = 0;
        req_valid = 4'b0011; req_last = 4'b0010;
        set_data(0, 8'hC0); set_data(1, 8'hD0);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk);
            if (b == 0) chk("burst_first_ready", 32'(req_ready), 32'h1);
            if (b > 0) begin
                chk("burst_data", 32'(out_data), 32'(exp_d[b - 1]));
                chk("burst_busy", 32'(busy), 32'(exp_b[b - 1]));
            end
            acc = req_valid & req_ready;
            step();
            if (acc[0]) c0++;
            req_valid[0] = (c0 < 4);
            req_last[0]  = (c0 == 3);
            set_data(0, 8'(8'hC0 + c0));
        end

        req_valid = '0;
        repeat (3) step();
        chk("end_out_valid", 32'(out_valid), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
